// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    input  logic [REG_ADDR_W-1:0] wd_i,
    output logic [XLEN-1:0]       result,
    output logic                  out_valid,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  busy,
    output logic                  stall_req
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            op_r;
    logic [REG_ADDR_W-1:0] wd_r;
    logic [XLEN-1:0]       opd_r;      // multiplicand for MUL*, divisor for DIV*
    logic [2*XLEN-1:0]     acc;        // {partial hi, multiplier} or {remainder, dividend/quotient}
    logic                  neg_r;
    logic                  rem_neg_r;
    logic                  out_valid_r;

    logic                  signed_a, signed_b, a_neg, b_neg, b_zero, div_ovf, fast;
    logic [XLEN-1:0]       a_abs, b_abs, fast_res;

    always_comb begin
        signed_a = (funct3 == 3'd1) || !funct3[0];
        signed_b = (funct3 == 3'd1) || (!funct3[0] && funct3 != 3'd2);
        a_neg    = signed_a && op_a[XLEN-1];
        b_neg    = signed_b && op_b[XLEN-1];
        a_abs    = a_neg ? -op_a : op_a;
        b_abs    = b_neg ? -op_b : op_b;
        b_zero   = (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (&op_b);
        fast     = funct3[2] && (b_zero || div_ovf);
        if (funct3[1])
            fast_res = b_zero ? op_a : '0;
        else
            fast_res = b_zero ? '1 : op_a;
    end

    logic [XLEN+BITS_PER_CYCLE-1:0] mul_sum;
    logic [2*XLEN-1:0]              mul_next, div_next, step, prod_fix;
    logic [XLEN:0]                  dr;
    logic [XLEN-1:0]                dq, calc_res;

    always_comb begin
        mul_sum  = {{BITS_PER_CYCLE{1'b0}}, acc[2*XLEN-1:XLEN]}
                 + ({{BITS_PER_CYCLE{1'b0}}, opd_r} * {{XLEN{1'b0}}, acc[BITS_PER_CYCLE-1:0]});
        mul_next = {mul_sum, acc[XLEN-1:BITS_PER_CYCLE]};

        // Restoring division: shift one dividend bit into the remainder, subtract if it fits
        dr = {1'b0, acc[2*XLEN-1:XLEN]};
        dq = acc[XLEN-1:0];
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            dr = {dr[XLEN-1:0], dq[XLEN-1]};
            dq = {dq[XLEN-2:0], 1'b0};
            if (dr >= {1'b0, opd_r}) begin
                dr    = dr - {1'b0, opd_r};
                dq[0] = 1'b1;
            end
        end
        div_next = {dr[XLEN-1:0], dq};

        step     = op_r[2] ? div_next : mul_next;
        prod_fix = neg_r ? -step : step;
        if (!op_r[2])
            calc_res = (op_r == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (op_r[1])
            calc_res = rem_neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        else
            calc_res = neg_r ? -step[XLEN-1:0] : step[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_r        <= '0;
            wd_r        <= '0;
            opd_r       <= '0;
            acc         <= '0;
            neg_r       <= 1'b0;
            rem_neg_r   <= 1'b0;
            out_valid_r <= 1'b0;
            result      <= '0;
            wd_o        <= '0;
        end else if (rdy) begin
            out_valid_r <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (in_valid) begin
                            op_r      <= funct3;
                            wd_r      <= wd_i;
                            opd_r     <= funct3[2] ? b_abs : a_abs;
                            acc       <= {{XLEN{1'b0}}, funct3[2] ? a_abs : b_abs};
                            neg_r     <= a_neg ^ b_neg;
                            rem_neg_r <= a_neg;
                            cnt       <= '0;
                            if (fast) begin
                                state       <= DONE;
                                result      <= fast_res;
                                out_valid_r <= 1'b1;
                                wd_o        <= wd_i;
                            end else begin
                                state <= CALC;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        acc <= step;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state       <= DONE;
                            result      <= calc_res;
                            out_valid_r <= 1'b1;
                            wd_o        <= wd_r;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A flush in the result cycle must suppress the write immediately
    assign out_valid = out_valid_r && !flush;
    assign wreg_o    = out_valid;
    assign busy      = (state != IDLE);
    assign stall_req = !flush && ((state == IDLE && in_valid) || state == CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized and directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rdy = 1'b1;
    logic             flush = 1'b0;
    logic [1:0]       iv = 2'b00;
    logic [2:0]       f3 = 3'd0;
    logic [31:0]      a = 32'd0;
    logic [31:0]      b = 32'd0;
    logic [4:0]       wd = 5'd0;

    logic [1:0][31:0] res;
    logic [1:0][4:0]  wdo;
    logic [1:0]       ov, wreg, busy, stall;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Instance 0: one bit per cycle; instance 1: four bits per cycle
    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .REG_ADDR_W(5)) u_bpc1 (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(iv[0]),
        .funct3(f3), .op_a(a), .op_b(b), .wd_i(wd),
        .result(res[0]), .out_valid(ov[0]), .wd_o(wdo[0]), .wreg_o(wreg[0]),
        .busy(busy[0]), .stall_req(stall[0])
    );

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .REG_ADDR_W(5)) u_bpc4 (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(iv[1]),
        .funct3(f3), .op_a(a), .op_b(b), .wd_i(wd),
        .result(res[1]), .out_valid(ov[1]), .wd_o(wdo[1]), .wreg_o(wreg[1]),
        .busy(busy[1]), .stall_req(stall[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy, ux, uy;
        logic [63:0] p;
        logic       ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'(x);
        uy  = longint'(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                p = sx % sy;
                return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input int k, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return ((k == 1) ? 8 : 32) + 1;
    endfunction

    // Behavioural model: pending op with a countdown to its result pulse
    bit          m_busy[2]  = '{0, 0};
    bit          m_pulse[2] = '{0, 0};
    int          m_left[2]  = '{0, 0};
    logic [31:0] m_res[2];
    logic [4:0]  m_wd[2];
    int          m_lat;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k]  = 0;
                m_pulse[k] = 0;
            end else if (rdy) begin
                if (flush) begin
                    m_busy[k]  = 0;
                    m_pulse[k] = 0;
                end else if (m_busy[k]) begin
                    m_pulse[k] = 0;
                    m_left[k]  = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_busy[k]  = 0;
                        m_pulse[k] = 1;
                    end
                end else begin
                    m_pulse[k] = 0;
                    if (iv[k]) begin
                        m_res[k] = ref_calc(f3, a, b);
                        m_wd[k]  = wd;
                        m_lat    = lat_of(k, f3, a, b);
                        if (m_lat == 1) begin
                            m_pulse[k] = 1;
                        end else begin
                            m_busy[k] = 1;
                            m_left[k] = m_lat - 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic exp_ov;
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_ov = m_pulse[k] && !flush;
                chk("out_valid", 32'(ov[k]), 32'(exp_ov));
                chk("wreg_o", 32'(wreg[k]), 32'(exp_ov));
                chk("busy", 32'(busy[k]), 32'(m_busy[k] || m_pulse[k]));
                chk("stall_req", 32'(stall[k]), 32'(!flush && (m_busy[k] || (!m_pulse[k] && iv[k]))));
                if (exp_ov) begin
                    chk("result", res[k], m_res[k]);
                    chk("wd_o", 32'(wdo[k]), 32'(m_wd[k]));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where out_valid is seen
    task automatic run_op(input int k, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] d, input logic [31:0] exp_res, input int exp_lat);
        int n;
        f3 = f; a = x; b = y; wd = d;
        iv[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0;
        n = 1;
        while (!ov[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("op_result", res[k], exp_res);
        chk("op_wd", 32'(wdo[k]), 32'(d));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          k;
        logic [2:0]  rf;
        logic [31:0] rx, ry;

        chk("ref_mul", ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("ref_mulhsu", ref_calc(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("ref_rem", ref_calc(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("ref_div_ovf", ref_calc(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        repeat (3) @(negedge clk);
        chk("reset_result", res[0], 32'd0);
        chk("reset_wd_o", 32'(wdo[0]), 32'd0);
        rst = 1'b0;

        run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 33);
        run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33);
        run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33);
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
        run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
        run_op(0, 3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 33);
        run_op(0, 3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 33);
        run_op(0, 3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run_op(0, 3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
        run_op(1, 3'd5, 32'hFFFF_FFFF, 32'h10, 5'd13, 32'h0FFF_FFFF, 9);
        run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd14, 32'hFFFF_FFEB, 9);

        // Flush at CALC cycle 10
        f3 = 3'd0; a = 32'd1234; b = 32'd5678; wd = 5'd20;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy[0]), 32'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov[0]) n++;
        end
        chk("flush_no_pulse", n, 0);
        run_op(0, 3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 33);

        // rdy low for 5 cycles mid-CALC
        f3 = 3'd0; a = 32'hFFFF_FFFB; b = 32'd6; wd = 5'd16;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        n = 1;
        repeat (4) begin @(negedge clk); n++; end
        rdy = 1'b0;
        repeat (5) begin @(negedge clk); n++; end
        rdy = 1'b1;
        while (!ov[0] && n < 100) begin @(negedge clk); n++; end
        chk("rdy_latency", n, 38);
        chk("rdy_result", res[0], 32'hFFFF_FFE2);

        // Reset mid-CALC on the 4-bit instance
        f3 = 3'd5; a = 32'd999; b = 32'd3; wd = 5'd17;
        iv[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_result", res[1], 32'd0);
        chk("rst_out_valid", 32'(ov[1]), 32'd0);
        chk("rst_wd_o", 32'(wdo[1]), 32'd0);
        chk("rst_wreg_o", 32'(wreg[1]), 32'd0);
        chk("rst_busy", 32'(busy[1]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Random ops, issued back-to-back into the result cycle
        repeat (40) begin
            k  = $urandom_range(0, 1);
            rf = 3'($urandom_range(0, 7));
            rx = pick();
            ry = pick();
            run_op(k, rf, rx, ry, 5'($urandom_range(0, 31)), ref_calc(rf, rx, ry), lat_of(k, rf, rx, ry));
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
